// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: request payload, FSM state and owner encodings.
// Supplies a fallback ICACHE_LINE_WIDTH when the SoC header has not defined it.
`ifndef ICACHE_LINE_WIDTH
`define ICACHE_LINE_WIDTH 128
`endif

package memory_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned REQ_DATA_WIDTH = `ICACHE_LINE_WIDTH;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     addr;
    logic                      is_store;
    logic [REQ_DATA_WIDTH-1:0] data;
  } memory_request_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } arb_state_t;

  typedef enum logic {
    OwnerIcache,
    OwnerDcache
  } arb_owner_t;

endpackage

// File: rtl/arb_pending_slot.sv
// One-entry request buffer with load/clear; a load in the same cycle as a clear wins.
// Loads are ignored while the slot already holds a request that is not being cleared.
module arb_pending_slot
  import memory_arbiter_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  memory_request_t load_info,
  input  logic            clear,
  output logic            valid,
  output memory_request_t info
);

  logic            valid_q;
  memory_request_t info_q;
  logic            accept;

  assign accept = load && (!valid_q || clear);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      info_q  <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      info_q  <= load_info;
    end else if (clear) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign info  = info_q;

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates I$ and D$ line requests onto one main-memory port, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise D$ has fixed priority.
`ifndef ICACHE_LINE_WIDTH
`define ICACHE_LINE_WIDTH 128
`endif

module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = `ICACHE_LINE_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  icache_req_valid,
  input  memory_request_t       icache_req_info,
  output logic                  icache_rsp_valid,
  output logic [LINE_WIDTH-1:0] icache_rsp_data,
  output logic                  icache_rsp_bus_error,
  input  logic                  dcache_req_valid,
  input  memory_request_t       dcache_req_info,
  output logic                  dcache_rsp_valid,
  output logic [LINE_WIDTH-1:0] dcache_rsp_data,
  output logic                  dcache_rsp_bus_error,
  output logic                  mem_req_valid,
  output memory_request_t       mem_req_info,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [LINE_WIDTH-1:0] mem_rsp_data,
  input  logic                  mem_rsp_bus_error
);

  arb_state_t      state_q, state_d;
  arb_owner_t      owner_q, owner_d;
  arb_owner_t      winner;
  logic            islot_valid, dslot_valid;
  memory_request_t islot_info, dslot_info;
  logic            rsp_done;
  logic            iclear, dclear;

  assign rsp_done = (state_q == StWait) && mem_rsp_valid;
  assign iclear   = rsp_done && (owner_q == OwnerIcache);
  assign dclear   = rsp_done && (owner_q == OwnerDcache);

  arb_pending_slot u_islot (
    .clock     (clock),
    .reset     (reset),
    .load      (icache_req_valid),
    .load_info (icache_req_info),
    .clear     (iclear),
    .valid     (islot_valid),
    .info      (islot_info)
  );

  arb_pending_slot u_dslot (
    .clock     (clock),
    .reset     (reset),
    .load      (dcache_req_valid),
    .load_info (dcache_req_info),
    .clear     (dclear),
    .valid     (dslot_valid),
    .info      (dslot_info)
  );

`ifdef MEM_ARB_RR_EN
  arb_owner_t last_grant_q, last_grant_d;

  // On contention the requester not granted last wins.
  always_comb begin
    if (islot_valid && dslot_valid) begin
      winner = (last_grant_q == OwnerIcache) ? OwnerDcache : OwnerIcache;
    end else begin
      winner = dslot_valid ? OwnerDcache : OwnerIcache;
    end
  end
`else
  always_comb begin
    winner = dslot_valid ? OwnerDcache : OwnerIcache;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= OwnerIcache;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= OwnerIcache;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (islot_valid || dslot_valid) begin
          state_d      = StIssue;
          owner_d      = winner;
`ifdef MEM_ARB_RR_EN
          last_grant_d = winner;
`endif
        end
      end
      StIssue: begin
        if (mem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (mem_rsp_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req_valid = (state_q == StIssue);
    mem_req_info  = '0;
    if (state_q == StIssue) begin
      mem_req_info = (owner_q == OwnerDcache) ? dslot_info : islot_info;
    end
    icache_rsp_valid     = iclear;
    icache_rsp_bus_error = iclear && mem_rsp_bus_error;
    dcache_rsp_valid     = dclear;
    dcache_rsp_bus_error = dclear && mem_rsp_bus_error;
    icache_rsp_data      = mem_rsp_data;
    dcache_rsp_data      = mem_rsp_data;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level model of slots, grants and routing.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int unsigned LW = REQ_DATA_WIDTH;

  logic            clock = 1'b0;
  logic            reset;
  logic            icache_req_valid, dcache_req_valid;
  memory_request_t icache_req_info, dcache_req_info;
  logic            icache_rsp_valid, dcache_rsp_valid;
  logic [LW-1:0]   icache_rsp_data, dcache_rsp_data;
  logic            icache_rsp_bus_error, dcache_rsp_bus_error;
  logic            mem_req_valid, mem_req_ready;
  memory_request_t mem_req_info;
  logic            mem_rsp_valid, mem_rsp_bus_error;
  logic [LW-1:0]   mem_rsp_data;

  memory_arbiter #(.LINE_WIDTH(LW)) dut (
    .clock                (clock),
    .reset                (reset),
    .icache_req_valid     (icache_req_valid),
    .icache_req_info      (icache_req_info),
    .icache_rsp_valid     (icache_rsp_valid),
    .icache_rsp_data      (icache_rsp_data),
    .icache_rsp_bus_error (icache_rsp_bus_error),
    .dcache_req_valid     (dcache_req_valid),
    .dcache_req_info      (dcache_req_info),
    .dcache_rsp_valid     (dcache_rsp_valid),
    .dcache_rsp_data      (dcache_rsp_data),
    .dcache_rsp_bus_error (dcache_rsp_bus_error),
    .mem_req_valid        (mem_req_valid),
    .mem_req_info         (mem_req_info),
    .mem_req_ready        (mem_req_ready),
    .mem_rsp_valid        (mem_rsp_valid),
    .mem_rsp_data         (mem_rsp_data),
    .mem_rsp_bus_error    (mem_rsp_bus_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pending request per requester (0 = I$, 1 = D$) and the single in-flight transaction.
  bit              pv [2];
  memory_request_t pinfo [2];
  bit              busy, acc;
  int              own, lastg, lat;

  logic            o_mrv, o_irv, o_drv, o_ibe, o_dbe;
  memory_request_t o_minfo;
  logic [LW-1:0]   o_idata;

  localparam logic [LW-1:0] DEADBEEF = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic memory_request_t mk(input logic [31:0] a, input logic s,
                                         input logic [LW-1:0] d);
    memory_request_t r;
    r.addr     = a;
    r.is_store = s;
    r.data     = d;
    return r;
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int pick(input bit iv, input bit dv);
`ifdef MEM_ARB_RR_EN
    if (iv && dv) return (lastg == 0) ? 1 : 0;
`endif
    return dv ? 1 : 0;
  endfunction

  task automatic reset_model();
    pv[0] = 0;
    pv[1] = 0;
    busy  = 0;
    acc   = 0;
    own   = 0;
    lastg = 0;
    lat   = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input bit ir, input memory_request_t ii, input bit dr,
                       input memory_request_t di, input bit rdy, input bit rv,
                       input logic [LW-1:0] rd, input bit be);
    bit pv0 [2];
    bit done;
    int own0;
    int w;
    icache_req_valid  = ir;
    icache_req_info   = ii;
    dcache_req_valid  = dr;
    dcache_req_info   = di;
    mem_req_ready     = rdy;
    mem_rsp_valid     = rv;
    mem_rsp_data      = rd;
    mem_rsp_bus_error = be;
    #1;
    o_mrv   = mem_req_valid;
    o_minfo = mem_req_info;
    o_irv   = icache_rsp_valid;
    o_drv   = dcache_rsp_valid;
    o_ibe   = icache_rsp_bus_error;
    o_dbe   = dcache_rsp_bus_error;
    o_idata = icache_rsp_data;
    done = busy && acc && rv;
    chk("mem_req_valid", mem_req_valid, busy && !acc);
    if (busy && !acc) chk("mem_req_info", mem_req_info, pinfo[own]);
    chk("icache_rsp_valid", icache_rsp_valid, done && own == 0);
    chk("dcache_rsp_valid", dcache_rsp_valid, done && own == 1);
    if (done && own == 0) chk("icache_rsp_bus_error", icache_rsp_bus_error, be);
    if (done && own == 1) chk("dcache_rsp_bus_error", dcache_rsp_bus_error, be);
    chk("icache_rsp_data", icache_rsp_data, rd);
    chk("dcache_rsp_data", dcache_rsp_data, rd);
    pv0  = pv;
    own0 = own;
    if (done) begin
      pv[own] = 0;
      busy    = 0;
      acc     = 0;
    end else if (busy && !acc) begin
      if (rdy) begin
        acc = 1;
        lat = $urandom_range(0, 3);
      end
    end else if (!busy && (pv0[0] || pv0[1])) begin
      w     = pick(pv0[0], pv0[1]);
      own   = w;
      lastg = w;
      busy  = 1;
      acc   = 0;
    end
    if (ir && (!pv0[0] || (done && own0 == 0))) begin
      pv[0]    = 1;
      pinfo[0] = ii;
    end
    if (dr && (!pv0[1] || (done && own0 == 1))) begin
      pv[1]    = 1;
      pinfo[1] = di;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input bit rdy, input bit rv, input logic [LW-1:0] rd, input bit be);
    cycle(0, '0, 0, '0, rdy, rv, rd, be);
  endtask

  initial begin
    logic [31:0] first_addr, second_addr;
    bit          rv;

    reset = 1'b1;
    icache_req_valid = 0; icache_req_info = '0;
    dcache_req_valid = 0; dcache_req_info = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0; mem_rsp_bus_error = 0;
    reset_model();
    repeat (2) @(posedge clock);
    #1;
    chk("reset mem_req_valid", mem_req_valid, 0);
    chk("reset mem_req_info", mem_req_info, 0);
    chk("reset icache_rsp_valid", icache_rsp_valid, 0);
    chk("reset dcache_rsp_valid", dcache_rsp_valid, 0);
    chk("reset icache_rsp_bus_error", icache_rsp_bus_error, 0);
    chk("reset dcache_rsp_bus_error", dcache_rsp_bus_error, 0);
    reset = 1'b0;

    // Lone I$ request, memory stalls 3 cycles.
    cycle(1, mk(32'h40, 0, '0), 0, '0, 0, 0, '0, 0);
    idle(0, 0, '0, 0);
    chk("lone N+1 no req", o_mrv, 0);
    idle(0, 0, '0, 0);
    chk("lone N+2 req", o_mrv, 1);
    chk("lone addr", o_minfo.addr, 32'h40);
    chk("lone is_store", o_minfo.is_store, 0);
    idle(0, 0, '0, 0);
    chk("lone stall addr", o_minfo.addr, 32'h40);
    idle(0, 0, '0, 0);
    chk("lone stall valid", o_mrv, 1);
    idle(1, 0, '0, 0);
    idle(0, 1, DEADBEEF, 0);
    chk("lone irsp", o_irv, 1);
    chk("lone drsp", o_drv, 0);
    chk("lone data", o_idata, DEADBEEF);
    idle(0, 0, '0, 0);
    chk("lone pulse width", o_irv, 0);

    // D$ store, which also leaves last grant = D$.
    cycle(0, '0, 1, mk(32'h80, 1, 'h1234), 0, 0, '0, 0);
    idle(0, 0, '0, 0);
    idle(1, 0, '0, 0);
    chk("store is_store", o_minfo.is_store, 1);
    chk("store data", o_minfo.data, 'h1234);
    chk("store addr", o_minfo.addr, 32'h80);
    idle(0, 1, rnd_line(), 0);
    chk("store drsp", o_drv, 1);
    chk("store irsp", o_irv, 0);

    // Simultaneous requests.
`ifdef MEM_ARB_RR_EN
    first_addr = 32'h100; second_addr = 32'h200;
`else
    first_addr = 32'h200; second_addr = 32'h100;
`endif
    cycle(1, mk(32'h100, 0, '0), 1, mk(32'h200, 0, '0), 0, 0, '0, 0);
    idle(0, 0, '0, 0);
    idle(1, 0, '0, 0);
    chk("simul first", o_minfo.addr, first_addr);
    idle(0, 1, rnd_line(), 0);
    idle(0, 0, '0, 0);
    idle(1, 0, '0, 0);
    chk("simul second", o_minfo.addr, second_addr);
    idle(0, 1, rnd_line(), 0);

    // Bus error on I$ with a D$ request queued behind it.
    cycle(1, mk(32'h300, 0, '0), 0, '0, 0, 0, '0, 0);
    idle(0, 0, '0, 0);
    cycle(0, '0, 1, mk(32'h400, 0, '0), 1, 0, '0, 0);
    idle(0, 1, rnd_line(), 1);
    chk("berr irsp", o_irv, 1);
    chk("berr flag", o_ibe, 1);
    idle(0, 0, '0, 0);
    chk("berr M+1", o_mrv, 0);
    idle(0, 0, '0, 0);
    chk("berr M+2 valid", o_mrv, 1);
    chk("berr M+2 addr", o_minfo.addr, 32'h400);
    idle(1, 0, '0, 0);
    idle(0, 1, rnd_line(), 0);

    // Reset while in WAIT.
    cycle(1, mk(32'h500, 0, '0), 0, '0, 0, 0, '0, 0);
    idle(0, 0, '0, 0);
    idle(1, 0, '0, 0);
    reset = 1'b1;
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = '0; mem_rsp_bus_error = 1;
    #1;
    chk("rst wait mem_req_valid", mem_req_valid, 0);
    chk("rst wait irsp", icache_rsp_valid, 0);
    chk("rst wait ibe", icache_rsp_bus_error, 0);
    chk("rst wait drsp", dcache_rsp_valid, 0);
    reset_model();
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(0, 1, rnd_line(), 0);
    chk("rst late rsp", o_irv, 0);
    idle(0, 0, '0, 0);

    // Same-cycle clear and load on D$.
    cycle(0, '0, 1, mk(32'h600, 0, '0), 0, 0, '0, 0);
    idle(0, 0, '0, 0);
    idle(1, 0, '0, 0);
    cycle(0, '0, 1, mk(32'h700, 1, 'h77), 0, 1, rnd_line(), 0);
    chk("reload drsp", o_drv, 1);
    idle(0, 0, '0, 0);
    chk("reload M+1", o_mrv, 0);
    idle(1, 0, '0, 0);
    chk("reload M+2 valid", o_mrv, 1);
    chk("reload M+2 addr", o_minfo.addr, 32'h700);
    idle(0, 1, rnd_line(), 0);

    // Random traffic, including spurious responses and readys outside their states.
    for (int c = 0; c < 3000; c++) begin
      rv = 0;
      if (acc) begin
        if (lat == 0) rv = 1;
        else lat--;
      end else begin
        rv = ($urandom_range(0, 7) == 0);
      end
      cycle($urandom_range(0, 4) == 0, mk($urandom, 1'b0, rnd_line()),
            $urandom_range(0, 4) == 0, mk($urandom, 1'($urandom_range(0, 1)), rnd_line()),
            $urandom_range(0, 2) != 0, rv, rnd_line(), $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
